// File: rtl/axil_share_arb_pkg.sv
// Shared types for the two-master AXI4-Lite register-bus arbiter.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } arb_state_t;

  typedef logic mst_id_t;

  localparam int CNT_W = 16;

  // Grant counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/axil_share_arb_if.sv
// AXI4-Lite bundle; master drives requests, slave drives readies and responses.
interface axi4_lite_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic            awvalid;
  logic            awready;
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            wvalid;
  logic            wready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic            arvalid;
  logic            arready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            rvalid;
  logic            rready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_share_arb_rr.sv
// Two-request round-robin picker; the priority pointer is kept by the caller.
module rr_arb2
  import axil_arb_pkg::*;
(
  input  logic [1:0] req,
  input  mst_id_t    prio,
  output mst_id_t    gnt_id,
  output logic       gnt_vld
);

  // Contention goes to prio, otherwise the lone requester wins.
  always_comb begin
    gnt_vld = |req;
    if (req == 2'b11) begin
      gnt_id = prio;
    end else if (req[1]) begin
      gnt_id = 1'b1;
    end else begin
      gnt_id = 1'b0;
    end
  end

endmodule

// File: rtl/axil_share_arb.sv
// Shares one AXI4-Lite register slave between two masters, one whole transaction at a time.
module axil_share_arb
  import axil_arb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter bit FIRST = 1'b0
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi4_lite_if.slave       s0,
  axi4_lite_if.slave       s1,
  axi4_lite_if.master      m,
  output logic             busy,
  output mst_id_t          grant_id,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  arb_state_t       state_r;
  mst_id_t          prio_r;
  mst_id_t          grant_id_r;
  logic [1:0]       last_wr_r;
  logic             aw_done_r;
  logic             w_done_r;
  logic             busy_r;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  logic [1:0]       awvalid_s, wvalid_s, arvalid_s, bready_s, rready_s;
  logic [1:0]       awready_s, wready_s, arready_s, bvalid_s, rvalid_s;
  logic [AW-1:0]    awaddr_s [2];
  logic [AW-1:0]    araddr_s [2];
  logic [2:0]       awprot_s [2];
  logic [2:0]       arprot_s [2];
  logic [DW-1:0]    wdata_s  [2];
  logic [DW/8-1:0]  wstrb_s  [2];

  logic [1:0]       req_s;
  mst_id_t          gnt_id_s;
  logic             gnt_vld_s;
  logic             wr_pick_s;
  logic             aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

  assign awvalid_s   = {s1.awvalid, s0.awvalid};
  assign wvalid_s    = {s1.wvalid,  s0.wvalid};
  assign arvalid_s   = {s1.arvalid, s0.arvalid};
  assign bready_s    = {s1.bready,  s0.bready};
  assign rready_s    = {s1.rready,  s0.rready};
  assign awaddr_s[0] = s0.awaddr;
  assign awaddr_s[1] = s1.awaddr;
  assign araddr_s[0] = s0.araddr;
  assign araddr_s[1] = s1.araddr;
  assign awprot_s[0] = s0.awprot;
  assign awprot_s[1] = s1.awprot;
  assign arprot_s[0] = s0.arprot;
  assign arprot_s[1] = s1.arprot;
  assign wdata_s[0]  = s0.wdata;
  assign wdata_s[1]  = s1.wdata;
  assign wstrb_s[0]  = s0.wstrb;
  assign wstrb_s[1]  = s1.wstrb;

  // Response payloads fan out to both; only the granted side ever sees a valid.
  assign s0.awready = awready_s[0];
  assign s1.awready = awready_s[1];
  assign s0.wready  = wready_s[0];
  assign s1.wready  = wready_s[1];
  assign s0.arready = arready_s[0];
  assign s1.arready = arready_s[1];
  assign s0.bvalid  = bvalid_s[0];
  assign s1.bvalid  = bvalid_s[1];
  assign s0.rvalid  = rvalid_s[0];
  assign s1.rvalid  = rvalid_s[1];
  assign s0.bresp   = m.bresp;
  assign s1.bresp   = m.bresp;
  assign s0.rdata   = m.rdata;
  assign s1.rdata   = m.rdata;
  assign s0.rresp   = m.rresp;
  assign s1.rresp   = m.rresp;

  // A write may be granted on AW alone; W is allowed to trail or lead.
  assign req_s = awvalid_s | arvalid_s;

  rr_arb2 u_rr (
    .req     (req_s),
    .prio    (prio_r),
    .gnt_id  (gnt_id_s),
    .gnt_vld (gnt_vld_s)
  );

  // Per-master read/write alternation when AW and AR are pending together.
  always_comb begin
    if (awvalid_s[gnt_id_s] && arvalid_s[gnt_id_s]) begin
      wr_pick_s = ~last_wr_r[gnt_id_s];
    end else if (awvalid_s[gnt_id_s]) begin
      wr_pick_s = 1'b1;
    end else begin
      wr_pick_s = 1'b0;
    end
  end

  // Channel steering from the granted master to the shared slave.
  always_comb begin
    m.awvalid = 1'b0;
    m.wvalid  = 1'b0;
    m.bready  = 1'b0;
    m.arvalid = 1'b0;
    m.rready  = 1'b0;
    m.awaddr  = awaddr_s[grant_id_r];
    m.awprot  = awprot_s[grant_id_r];
    m.wdata   = wdata_s[grant_id_r];
    m.wstrb   = wstrb_s[grant_id_r];
    m.araddr  = araddr_s[grant_id_r];
    m.arprot  = arprot_s[grant_id_r];
    awready_s = 2'b00;
    wready_s  = 2'b00;
    arready_s = 2'b00;
    bvalid_s  = 2'b00;
    rvalid_s  = 2'b00;
    case (state_r)
      WR_REQ: begin
        m.awvalid             = awvalid_s[grant_id_r] & ~aw_done_r;
        m.wvalid              = wvalid_s[grant_id_r] & ~w_done_r;
        awready_s[grant_id_r] = m.awready & ~aw_done_r;
        wready_s[grant_id_r]  = m.wready & ~w_done_r;
      end
      WR_RESP: begin
        m.bready             = bready_s[grant_id_r];
        bvalid_s[grant_id_r] = m.bvalid;
      end
      RD_REQ: begin
        m.arvalid             = arvalid_s[grant_id_r];
        arready_s[grant_id_r] = m.arready;
      end
      RD_RESP: begin
        m.rready             = rready_s[grant_id_r];
        rvalid_s[grant_id_r] = m.rvalid;
      end
      default: begin
        m.awvalid = 1'b0;
      end
    endcase
  end

  assign aw_hs_s = m.awvalid & m.awready;
  assign w_hs_s  = m.wvalid & m.wready;
  assign b_hs_s  = m.bvalid & m.bready;
  assign ar_hs_s = m.arvalid & m.arready;
  assign r_hs_s  = m.rvalid & m.rready;

  // Transaction FSM; arbitration is only re-evaluated from IDLE.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r    <= IDLE;
      prio_r     <= mst_id_t'(FIRST);
      grant_id_r <= mst_id_t'(FIRST);
      last_wr_r  <= 2'b00;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      busy_r     <= 1'b0;
      cnt0_r     <= {CNT_W{1'b0}};
      cnt1_r     <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_vld_s) begin
            grant_id_r          <= gnt_id_s;
            prio_r              <= ~gnt_id_s;
            last_wr_r[gnt_id_s] <= wr_pick_s;
            aw_done_r           <= 1'b0;
            w_done_r            <= 1'b0;
            busy_r              <= 1'b1;
            state_r             <= wr_pick_s ? WR_REQ : RD_REQ;
            if (gnt_id_s == 1'b1) begin
              cnt1_r <= sat_inc(cnt1_r);
            end else begin
              cnt0_r <= sat_inc(cnt0_r);
            end
          end
        end
        WR_REQ: begin
          aw_done_r <= aw_done_r | aw_hs_s;
          w_done_r  <= w_done_r | w_hs_s;
          if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
            state_r <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        RD_REQ: begin
          if (ar_hs_s) begin
            state_r <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (r_hs_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign grant_id   = grant_id_r;
  assign grant_cnt0 = cnt0_r;
  assign grant_cnt1 = cnt1_r;

endmodule

// File: tb/tb_axil_share_arb.sv
// Directed bench for axil_share_arb with two scripted masters and a small register slave.
module tb_axil_share_arb;
  import axil_arb_pkg::*;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  axi4_lite_if #(.DW(32), .AW(32)) s0_if ();
  axi4_lite_if #(.DW(32), .AW(32)) s1_if ();
  axi4_lite_if #(.DW(32), .AW(32)) m_if ();

  logic        busy;
  mst_id_t     grant_id;
  logic [15:0] grant_cnt0, grant_cnt1;

  axil_share_arb #(.DW(32), .AW(32), .FIRST(1'b0)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s0         (s0_if),
    .s1         (s1_if),
    .m          (m_if),
    .busy       (busy),
    .grant_id   (grant_id),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  // Master-side drive
  logic        s_awvalid [2];
  logic        s_wvalid  [2];
  logic        s_arvalid [2];
  logic        s_bready  [2];
  logic        s_rready  [2];
  logic [31:0] s_awaddr  [2];
  logic [31:0] s_araddr  [2];
  logic [31:0] s_wdata   [2];

  assign s0_if.awvalid = s_awvalid[0];
  assign s1_if.awvalid = s_awvalid[1];
  assign s0_if.wvalid  = s_wvalid[0];
  assign s1_if.wvalid  = s_wvalid[1];
  assign s0_if.arvalid = s_arvalid[0];
  assign s1_if.arvalid = s_arvalid[1];
  assign s0_if.bready  = s_bready[0];
  assign s1_if.bready  = s_bready[1];
  assign s0_if.rready  = s_rready[0];
  assign s1_if.rready  = s_rready[1];
  assign s0_if.awaddr  = s_awaddr[0];
  assign s1_if.awaddr  = s_awaddr[1];
  assign s0_if.araddr  = s_araddr[0];
  assign s1_if.araddr  = s_araddr[1];
  assign s0_if.wdata   = s_wdata[0];
  assign s1_if.wdata   = s_wdata[1];
  assign s0_if.awprot  = 3'b000;
  assign s1_if.awprot  = 3'b000;
  assign s0_if.arprot  = 3'b000;
  assign s1_if.arprot  = 3'b000;
  assign s0_if.wstrb   = 4'hF;
  assign s1_if.wstrb   = 4'hF;

  logic        awready_w [2];
  logic        wready_w  [2];
  logic        arready_w [2];
  logic        bvalid_w  [2];
  logic        rvalid_w  [2];
  logic [1:0]  bresp_w   [2];
  logic [1:0]  rresp_w   [2];
  logic [31:0] rdata_w   [2];
  assign awready_w[0] = s0_if.awready;
  assign awready_w[1] = s1_if.awready;
  assign wready_w[0]  = s0_if.wready;
  assign wready_w[1]  = s1_if.wready;
  assign arready_w[0] = s0_if.arready;
  assign arready_w[1] = s1_if.arready;
  assign bvalid_w[0]  = s0_if.bvalid;
  assign bvalid_w[1]  = s1_if.bvalid;
  assign rvalid_w[0]  = s0_if.rvalid;
  assign rvalid_w[1]  = s1_if.rvalid;
  assign bresp_w[0]   = s0_if.bresp;
  assign bresp_w[1]   = s1_if.bresp;
  assign rresp_w[0]   = s0_if.rresp;
  assign rresp_w[1]   = s1_if.rresp;
  assign rdata_w[0]   = s0_if.rdata;
  assign rdata_w[1]   = s1_if.rdata;

  // Slave model: always ready, responds one cycle after the request completes
  logic [1:0]  slv_bresp;
  logic [1:0]  slv_rresp;
  logic [31:0] slv_rdata;
  logic        sl_got_aw, sl_got_w, sl_b_pend, sl_bvalid, sl_r_pend, sl_rvalid;
  logic [1:0]  sl_bresp, sl_rresp;
  logic [31:0] sl_rdata, cap_awaddr, cap_wdata, cap_araddr;
  int          m_aw_cnt, m_w_cnt, log_n;
  logic [15:0] log_bits;

  assign m_if.awready = 1'b1;
  assign m_if.wready  = 1'b1;
  assign m_if.arready = 1'b1;
  assign m_if.bvalid  = sl_bvalid;
  assign m_if.bresp   = sl_bresp;
  assign m_if.rvalid  = sl_rvalid;
  assign m_if.rresp   = sl_rresp;
  assign m_if.rdata   = sl_rdata;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sl_got_aw <= 1'b0; sl_got_w <= 1'b0; sl_b_pend <= 1'b0; sl_bvalid <= 1'b0;
      sl_r_pend <= 1'b0; sl_rvalid <= 1'b0; sl_bresp <= 2'b00; sl_rresp <= 2'b00;
      sl_rdata <= 32'h0; cap_awaddr <= 32'h0; cap_wdata <= 32'h0; cap_araddr <= 32'h0;
      m_aw_cnt <= 0; m_w_cnt <= 0; log_n <= 0; log_bits <= 16'h0;
    end else begin
      if (m_if.awvalid && m_if.awready) begin
        sl_got_aw <= 1'b1; cap_awaddr <= m_if.awaddr; m_aw_cnt <= m_aw_cnt + 1;
        log_bits[log_n] <= 1'b1; log_n <= log_n + 1;
      end
      if (m_if.wvalid && m_if.wready) begin
        sl_got_w <= 1'b1; cap_wdata <= m_if.wdata; m_w_cnt <= m_w_cnt + 1;
      end
      if ((sl_got_aw || (m_if.awvalid && m_if.awready)) && (sl_got_w || (m_if.wvalid && m_if.wready))) begin
        sl_got_aw <= 1'b0; sl_got_w <= 1'b0; sl_b_pend <= 1'b1;
      end
      if (sl_b_pend) begin
        sl_b_pend <= 1'b0; sl_bvalid <= 1'b1; sl_bresp <= slv_bresp;
      end
      if (sl_bvalid && m_if.bready) sl_bvalid <= 1'b0;
      if (m_if.arvalid && m_if.arready) begin
        sl_r_pend <= 1'b1; cap_araddr <= m_if.araddr;
        log_bits[log_n] <= 1'b0; log_n <= log_n + 1;
      end
      if (sl_r_pend) begin
        sl_r_pend <= 1'b0; sl_rvalid <= 1'b1; sl_rdata <= slv_rdata ^ cap_araddr; sl_rresp <= slv_rresp;
      end
      if (sl_rvalid && m_if.rready) sl_rvalid <= 1'b0;
    end
  end

  int busy_total = 0;
  always @(posedge aclk) if (busy === 1'b1) busy_total <= busy_total + 1;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [1:0]  got_bresp [2];
  logic [1:0]  got_rresp [2];
  logic [31:0] got_rdata [2];
  int          fin_order [2];
  int          done_seq;
  int          stall_cnt, stall_bad, early_w;
  logic [31:0] stall_exp;

  task automatic apply_reset();
    aresetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_awvalid[i] = 1'b0; s_wvalid[i] = 1'b0; s_arvalid[i] = 1'b0;
      s_bready[i] = 1'b0; s_rready[i] = 1'b0;
      s_awaddr[i] = 32'h0; s_araddr[i] = 32'h0; s_wdata[i] = 32'h0;
    end
    repeat (3) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  // Scripted master: optional write (W may lead AW) and/or read, with rready hold-off
  task automatic run_master(input int id, input bit wr, input bit rd, input logic [31:0] addr,
                            input logic [31:0] wdat, input int w_lead, input int r_hold);
    bit aw_ok, w_ok, ar_ok, b_ok, r_ok, hs_aw, hs_w, hs_ar, hs_b, hs_r;
    int hold;
    aw_ok = !wr; w_ok = !wr; b_ok = !wr; ar_ok = !rd; r_ok = !rd; hold = 0;
    s_awaddr[id] = addr; s_araddr[id] = addr; s_wdata[id] = wdat;
    if (wr) begin
      s_wvalid[id] = 1'b1;
      for (int i = 0; i < w_lead; i++) begin
        @(negedge aclk);
        if (wready_w[id] === 1'b1) early_w++;
        @(posedge aclk); #1;
      end
      s_awvalid[id] = 1'b1;
    end
    if (rd) s_arvalid[id] = 1'b1;
    s_bready[id] = wr;
    s_rready[id] = (r_hold == 0);
    for (int c = 0; c < 300 && !(aw_ok && w_ok && ar_ok && b_ok && r_ok); c++) begin
      @(negedge aclk);
      hs_aw = s_awvalid[id] && awready_w[id] === 1'b1;
      hs_w  = s_wvalid[id] && wready_w[id] === 1'b1;
      hs_ar = s_arvalid[id] && arready_w[id] === 1'b1;
      hs_b  = s_bready[id] && bvalid_w[id] === 1'b1;
      hs_r  = s_rready[id] && rvalid_w[id] === 1'b1;
      if (hs_b) got_bresp[id] = bresp_w[id];
      if (hs_r) begin
        got_rresp[id] = rresp_w[id]; got_rdata[id] = rdata_w[id];
        fin_order[id] = done_seq; done_seq++;
      end
      if (rvalid_w[id] === 1'b1 && !s_rready[id]) begin
        stall_cnt++; hold++;
        if (rdata_w[id] !== stall_exp || rresp_w[id] !== 2'b10 || busy !== 1'b1 || m_if.rvalid !== 1'b1)
          stall_bad++;
      end
      @(posedge aclk); #1;
      if (hs_aw) begin s_awvalid[id] = 1'b0; aw_ok = 1'b1; end
      if (hs_w)  begin s_wvalid[id] = 1'b0;  w_ok = 1'b1;  end
      if (hs_ar) begin s_arvalid[id] = 1'b0; ar_ok = 1'b1; end
      if (hs_b)  begin s_bready[id] = 1'b0;  b_ok = 1'b1;  end
      if (hs_r)  begin s_rready[id] = 1'b0;  r_ok = 1'b1;  end
      if (!r_ok && rd && hold >= r_hold) s_rready[id] = 1'b1;
    end
    n_checks++;
    if (!(aw_ok && w_ok && ar_ok && b_ok && r_ok)) begin
      n_fail++;
      $display("FAIL timeout_m%0d: got aw%0d w%0d ar%0d b%0d r%0d required all 1", id, aw_ok, w_ok, ar_ok, b_ok, r_ok);
      s_awvalid[id] = 1'b0; s_wvalid[id] = 1'b0; s_arvalid[id] = 1'b0; s_bready[id] = 1'b0; s_rready[id] = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL rst_grant_id: got %b required 0", grant_id); end
    n_checks++; if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
      n_fail++; $display("FAIL rst_cnt: got %0d/%0d required 0/0", grant_cnt0, grant_cnt1); end
    n_checks++; if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready} !== 5'b00000) begin
      n_fail++; $display("FAIL rst_m_valids: got %b required 00000", {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready}); end
    n_checks++; if ({s0_if.awready, s0_if.wready, s0_if.arready, s1_if.bvalid, s1_if.rvalid} !== 5'b00000) begin
      n_fail++; $display("FAIL rst_s_readys: got %b required 00000", {s0_if.awready, s0_if.wready, s0_if.arready, s1_if.bvalid, s1_if.rvalid}); end
  endtask

  task automatic test_single_write();
    int b0;
    apply_reset();
    slv_bresp = 2'b00;
    b0 = busy_total;
    run_master(0, 1'b1, 1'b0, 32'h10, 32'hA5A5_0001, 0, 0);
    n_checks++; if (cap_awaddr !== 32'h10) begin n_fail++; $display("FAIL wr_awaddr: got %h required 10", cap_awaddr); end
    n_checks++; if (cap_wdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL wr_wdata: got %h required a5a50001", cap_wdata); end
    n_checks++; if (got_bresp[0] !== 2'b00) begin n_fail++; $display("FAIL wr_bresp: got %b required 00", got_bresp[0]); end
    n_checks++; if ((busy_total - b0) < 3 || (busy_total - b0) > 4) begin
      n_fail++; $display("FAIL wr_busy_len: got %0d required 3..4", busy_total - b0); end
    n_checks++; if (grant_cnt0 !== 16'd1 || grant_cnt1 !== 16'd0) begin
      n_fail++; $display("FAIL wr_cnt: got %0d/%0d required 1/0", grant_cnt0, grant_cnt1); end
    n_checks++; if (m_aw_cnt != 1 || m_w_cnt != 1) begin
      n_fail++; $display("FAIL wr_beats: got aw%0d w%0d required aw1 w1", m_aw_cnt, m_w_cnt); end
  endtask

  task automatic test_rr_read();
    apply_reset();
    slv_rdata = 32'h1234_0000; slv_rresp = 2'b00;
    for (int round = 0; round < 2; round++) begin
      done_seq = 0;
      fork
        run_master(0, 1'b0, 1'b1, 32'h100, 32'h0, 0, 0);
        run_master(1, 1'b0, 1'b1, 32'h200, 32'h0, 0, 0);
      join
      n_checks++; if (fin_order[0] != 0 || fin_order[1] != 1) begin
        n_fail++; $display("FAIL rr_order_r%0d: got s0=%0d s1=%0d required s0=0 s1=1", round, fin_order[0], fin_order[1]); end
    end
    n_checks++; if (got_rdata[0] !== 32'h1234_0100 || got_rdata[1] !== 32'h1234_0200) begin
      n_fail++; $display("FAIL rr_rdata: got %h/%h required 12340100/12340200", got_rdata[0], got_rdata[1]); end
    n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL rr_grant_hold: got %b required 1", grant_id); end
    run_master(0, 1'b0, 1'b1, 32'h104, 32'h0, 0, 0);
    done_seq = 0;
    fork
      run_master(0, 1'b0, 1'b1, 32'h108, 32'h0, 0, 0);
      run_master(1, 1'b0, 1'b1, 32'h20C, 32'h0, 0, 0);
    join
    n_checks++; if (fin_order[1] != 0 || fin_order[0] != 1) begin
      n_fail++; $display("FAIL rr_prio_s1: got s0=%0d s1=%0d required s0=1 s1=0", fin_order[0], fin_order[1]); end
    n_checks++; if (grant_cnt0 !== 16'd4 || grant_cnt1 !== 16'd3) begin
      n_fail++; $display("FAIL rr_cnt: got %0d/%0d required 4/3", grant_cnt0, grant_cnt1); end
  endtask

  task automatic test_wr_rd_both();
    apply_reset();
    slv_bresp = 2'b00; slv_rdata = 32'hCAFE_0000; slv_rresp = 2'b00;
    run_master(1, 1'b1, 1'b1, 32'h40, 32'h1111_2222, 0, 0);
    run_master(1, 1'b1, 1'b1, 32'h44, 32'h3333_4444, 0, 0);
    n_checks++; if (log_n != 4 || log_bits[3:0] !== 4'b0101) begin
      n_fail++; $display("FAIL both_order: got n=%0d bits=%b required n=4 bits=0101", log_n, log_bits[3:0]); end
    n_checks++; if (got_rdata[1] !== 32'hCAFE_0044 || cap_wdata !== 32'h3333_4444) begin
      n_fail++; $display("FAIL both_data: got r=%h w=%h required cafe0044/33334444", got_rdata[1], cap_wdata); end
    n_checks++; if (grant_cnt1 !== 16'd4 || grant_cnt0 !== 16'd0) begin
      n_fail++; $display("FAIL both_cnt: got %0d/%0d required 0/4", grant_cnt0, grant_cnt1); end
  endtask

  task automatic test_w_early();
    apply_reset();
    slv_bresp = 2'b00; early_w = 0;
    run_master(0, 1'b1, 1'b0, 32'h20, 32'h0BAD_F00D, 5, 0);
    n_checks++; if (early_w != 0) begin n_fail++; $display("FAIL wlead_ready: got %0d early wready required 0", early_w); end
    n_checks++; if (m_aw_cnt != 1 || m_w_cnt != 1 || cap_wdata !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL wlead_beats: got aw%0d w%0d d=%h required aw1 w1 0badf00d", m_aw_cnt, m_w_cnt, cap_wdata); end
    slv_bresp = 2'b10;
    run_master(0, 1'b1, 1'b0, 32'h24, 32'h600D_F00D, 0, 0);
    n_checks++; if (m_aw_cnt != 2 || m_w_cnt != 2 || cap_awaddr !== 32'h24) begin
      n_fail++; $display("FAIL wsame_beats: got aw%0d w%0d a=%h required aw2 w2 24", m_aw_cnt, m_w_cnt, cap_awaddr); end
    n_checks++; if (got_bresp[0] !== 2'b10) begin n_fail++; $display("FAIL wsame_bresp: got %b required 10", got_bresp[0]); end
  endtask

  task automatic test_rd_error_hold();
    apply_reset();
    slv_rdata = 32'hDEAD_BEEF; slv_rresp = 2'b10; stall_exp = 32'hDEAD_BEEF;
    stall_cnt = 0; stall_bad = 0;
    run_master(0, 1'b0, 1'b1, 32'h0, 32'h0, 0, 3);
    n_checks++; if (got_rdata[0] !== 32'hDEAD_BEEF || got_rresp[0] !== 2'b10) begin
      n_fail++; $display("FAIL rderr_data: got %h/%b required deadbeef/10", got_rdata[0], got_rresp[0]); end
    n_checks++; if (stall_cnt != 3 || stall_bad != 0) begin
      n_fail++; $display("FAIL rderr_hold: got %0d cycles %0d bad required 3 cycles 0 bad", stall_cnt, stall_bad); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    apply_reset();
    slv_bresp = 2'b00; seen = 1'b0;
    s_awaddr[0] = 32'h30; s_wdata[0] = 32'h7777_0000;
    s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_bready[0] = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge aclk);
      if (m_if.bvalid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_reach_resp: got no bvalid required bvalid"); end
    n_checks++; if (s0_if.bvalid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: got bvalid=%b busy=%b required 1/1", s0_if.bvalid, busy); end
    s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0;
    aresetn = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || grant_cnt0 !== 16'd0 || grant_id !== 1'b0) begin
      n_fail++; $display("FAIL mid_regs: got busy=%b cnt0=%0d gid=%b required 0/0/0", busy, grant_cnt0, grant_id); end
    n_checks++; if ({m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready, s0_if.bvalid, s0_if.awready} !== 7'b0) begin
      n_fail++; $display("FAIL mid_handshake: got %b required 0000000",
        {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.bready, m_if.rready, s0_if.bvalid, s0_if.awready}); end
    repeat (2) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    slv_rdata = 32'h5555_0000; slv_rresp = 2'b00;
    run_master(1, 1'b0, 1'b1, 32'h8, 32'h0, 0, 0);
    n_checks++; if (got_rdata[1] !== 32'h5555_0008 || got_rresp[1] !== 2'b00) begin
      n_fail++; $display("FAIL mid_after_rd: got %h/%b required 55550008/00", got_rdata[1], got_rresp[1]); end
    n_checks++; if (grant_cnt1 !== 16'd1 || grant_cnt0 !== 16'd0) begin
      n_fail++; $display("FAIL mid_after_cnt: got %0d/%0d required 0/1", grant_cnt0, grant_cnt1); end
  endtask

  initial begin
    slv_bresp = 2'b00; slv_rresp = 2'b00; slv_rdata = 32'h0;
    done_seq = 0; stall_cnt = 0; stall_bad = 0; early_w = 0; stall_exp = 32'h0;
    test_reset();
    test_single_write();
    test_rr_read();
    test_wr_rd_both();
    test_w_early();
    test_rd_error_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
